uart_cmd_dispatcher: RTL and testbench

//  Frames the UART receive byte stream into addressed commands and routes them to one of
//  N_TARGETS addressable control blocks sharing the single Rx channel.

---
 rtl/uart_dispatch_pkg.sv | 27 ++
 rtl/uart_cmd_dispatcher_timer.sv | 31 +++
 rtl/uart_cmd_dispatcher.sv | 199 +++++++++++++++++++
 tb/tb_uart_cmd_dispatcher.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dispatch_pkg.sv
// Shared types and helpers for the UART command dispatcher.
//   state_t   : frame parser states
//   err_t     : error codes reported on o_err_code
//   tmo_width : counter width able to hold the timeout value itself
// Optional feature macro: UART_DISPATCH_CSUM_EN (trailing XOR checksum byte).
package uart_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_LEN = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_ID   = 3'd1,
    ERR_BAD_LEN  = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_BAD_CSUM = 3'd4
  } err_t;

  function automatic int tmo_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/uart_cmd_dispatcher_timer.sv
// Inter-byte timeout timer.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : restart the count (byte accepted, or parser idle)
//   i_enable       : count this cycle (parser inside a frame)
//   o_expired      : combinational pulse in the cycle the count reaches TIMEOUT_CYCLES
module dispatch_timeout_timer
  import uart_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = tmo_width(TIMEOUT_CYCLES);

  logic [W-1:0] r_cnt;

  // Clear beats enable, so an accept in the expiry cycle suppresses the pulse.
  assign o_expired = i_enable && !i_clear && (r_cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) r_cnt <= '0;
    else if (i_enable)      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// UART command dispatcher: frames [id][len][payload x len] (plus a trailing
// XOR checksum byte when UART_DISPATCH_CSUM_EN is defined) and strobes the
// payload bytes to the addressed target. All outputs are registered (latency 1).
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_rx_ready          : UART byte-valid level, byte accepted on its rising edge
//   i_rx_data[7:0]      : UART byte
//   o_tgt_data[7:0]     : payload byte
//   o_tgt_valid[N-1:0]  : one-hot strobe for the selected target
//   o_tgt_first         : first payload byte of a frame
//   o_frame_done        : frame complete and good
//   o_frame_error       : frame aborted
//   o_err_code[2:0]     : last error code (held)
//   o_busy              : parser not idle
module uart_cmd_dispatcher
  import uart_dispatch_pkg::*;
#(
  parameter int          N_TARGETS      = 4,
  parameter logic [7:0]  BASE_ID        = 8'h14,
  parameter int          MAX_LEN        = 16,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_ready,
  input  logic [7:0]           i_rx_data,
  output logic [7:0]           o_tgt_data,
  output logic [N_TARGETS-1:0] o_tgt_valid,
  output logic                 o_tgt_first,
  output logic                 o_frame_done,
  output logic                 o_frame_error,
  output logic [2:0]           o_err_code,
  output logic                 o_busy
);

  localparam int SEL_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_prev;
  logic [SEL_W-1:0]     r_sel, w_sel_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;
  logic                 r_first, w_first_nxt;
  logic [7:0]           r_tgt_data, w_tgt_data_nxt;
  logic [N_TARGETS-1:0] r_tgt_valid, w_tgt_valid_nxt;
  logic                 r_tgt_first, w_tgt_first_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_error, w_error_nxt;
  err_t                 r_err_code, w_err_code_nxt;
`ifdef UART_DISPATCH_CSUM_EN
  logic [7:0]           r_csum, w_csum_nxt;
`endif

  logic       w_accept;
  logic       w_expired;
  logic [8:0] w_id_off;
  logic       w_id_ok;
  logic       w_len_ok;

  // The edge register tracks Rx_ready even during reset, so a byte already
  // presented before reset released is not mistaken for a fresh one.
  always_ff @(posedge i_clk) r_rx_prev <= i_rx_ready;

  assign w_accept = i_rx_ready && !r_rx_prev;
  assign w_id_off = {1'b0, i_rx_data} - {1'b0, BASE_ID};
  assign w_id_ok  = (i_rx_data >= BASE_ID) && (w_id_off < 9'(N_TARGETS));
  assign w_len_ok = (i_rx_data != 8'd0) && (int'(i_rx_data) <= MAX_LEN);

  dispatch_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_accept || (r_state == IDLE)),
    .i_enable  (r_state != IDLE),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_cnt_nxt       = r_cnt;
    w_first_nxt     = r_first;
    w_tgt_data_nxt  = r_tgt_data;
    w_tgt_valid_nxt = '0;
    w_tgt_first_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;
    w_err_code_nxt  = r_err_code;
`ifdef UART_DISPATCH_CSUM_EN
    w_csum_nxt      = r_csum;
`endif
    case (r_state)
      IDLE: if (w_accept) begin
        if (w_id_ok) begin
          w_sel_nxt   = SEL_W'(w_id_off);
          w_state_nxt = GET_LEN;
`ifdef UART_DISPATCH_CSUM_EN
          w_csum_nxt  = i_rx_data;
`endif
        end else begin
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_BAD_ID;
        end
      end
      GET_LEN: if (w_accept) begin
        if (w_len_ok) begin
          w_cnt_nxt   = i_rx_data;
          w_first_nxt = 1'b1;
          w_state_nxt = PAYLOAD;
`ifdef UART_DISPATCH_CSUM_EN
          w_csum_nxt  = r_csum ^ i_rx_data;
`endif
        end else begin
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_BAD_LEN;
          w_state_nxt    = IDLE;
        end
      end
      PAYLOAD: if (w_accept) begin
        w_tgt_data_nxt         = i_rx_data;
        w_tgt_valid_nxt[r_sel] = 1'b1;
        w_tgt_first_nxt        = r_first;
        w_first_nxt            = 1'b0;
        w_cnt_nxt              = r_cnt - 8'd1;
`ifdef UART_DISPATCH_CSUM_EN
        w_csum_nxt             = r_csum ^ i_rx_data;
        if (r_cnt == 8'd1) w_state_nxt = CHECK;
`else
        if (r_cnt == 8'd1) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
`endif
      end
      CHECK: begin
`ifdef UART_DISPATCH_CSUM_EN
        if (w_accept) begin
          w_state_nxt = IDLE;
          if (i_rx_data == r_csum) begin
            w_done_nxt = 1'b1;
          end else begin
            w_error_nxt    = 1'b1;
            w_err_code_nxt = ERR_BAD_CSUM;
          end
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    // Expiry never coincides with an accept, so it cannot collide with the
    // byte handling above.
    if (w_expired) begin
      w_error_nxt    = 1'b1;
      w_err_code_nxt = ERR_TIMEOUT;
      w_state_nxt    = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_tgt_data  <= '0;
      r_tgt_valid <= '0;
      r_tgt_first <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= ERR_NONE;
`ifdef UART_DISPATCH_CSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_cnt       <= w_cnt_nxt;
      r_first     <= w_first_nxt;
      r_tgt_data  <= w_tgt_data_nxt;
      r_tgt_valid <= w_tgt_valid_nxt;
      r_tgt_first <= w_tgt_first_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_err_code  <= w_err_code_nxt;
`ifdef UART_DISPATCH_CSUM_EN
      r_csum      <= w_csum_nxt;
`endif
    end
  end

  assign o_tgt_data    = r_tgt_data;
  assign o_tgt_valid   = r_tgt_valid;
  assign o_tgt_first   = r_tgt_first;
  assign o_frame_done  = r_done;
  assign o_frame_error = r_error;
  assign o_err_code    = r_err_code;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Scoreboard bench for uart_cmd_dispatcher (default parameters).
// Also covers the checksum frames when UART_DISPATCH_CSUM_EN is defined.
module tb_uart_cmd_dispatcher;

  localparam int T = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tgt_data;
  logic [3:0] tgt_valid;
  logic       tgt_first, frame_done, frame_error, busy;
  logic [2:0] err_code;

  uart_cmd_dispatcher dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_rx_ready    (rx_ready),
    .i_rx_data     (rx_data),
    .o_tgt_data    (tgt_data),
    .o_tgt_valid   (tgt_valid),
    .o_tgt_first   (tgt_first),
    .o_frame_done  (frame_done),
    .o_frame_error (frame_error),
    .o_err_code    (err_code),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [7:0] d;
    logic       f;
    logic       dn;
    logic       er;
    logic [2:0] c;
    int         dly;   // required cycles since previous event, 0 = any
  } exp_t;

  typedef logic [7:0] bq_t[$];

  exp_t       sb[$];
  exp_t       mon_e;
  bq_t        pay;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [2:0] exp_code = 3'd0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every strobe the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && (tgt_valid != 4'b0 || frame_done || frame_error)) begin
      n_cmp = n_cmp + 1;
      if (sb.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_event: valid=%b data=%h first=%b done=%b err=%b code=%0d, none required",
                 tgt_valid, tgt_data, tgt_first, frame_done, frame_error, err_code);
      end else begin
        mon_e = sb.pop_front();
        if (tgt_valid !== mon_e.v || (mon_e.v != 4'b0 && tgt_data !== mon_e.d) ||
            tgt_first !== mon_e.f || frame_done !== mon_e.dn || frame_error !== mon_e.er ||
            err_code !== mon_e.c || (mon_e.dly != 0 && cyc - last_cyc != mon_e.dly)) begin
          n_bad = n_bad + 1;
          $display("FAIL event: got valid=%b data=%h first=%b done=%b err=%b code=%0d gap=%0d; want valid=%b data=%h first=%b done=%b err=%b code=%0d gap=%0d",
                   tgt_valid, tgt_data, tgt_first, frame_done, frame_error, err_code, cyc - last_cyc,
                   mon_e.v, mon_e.d, mon_e.f, mon_e.dn, mon_e.er, mon_e.c, mon_e.dly);
        end
      end
      last_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic exp_tgt(input logic [3:0] v, input logic [7:0] d, input logic f, input logic dn);
    sb.push_back('{v: v, d: d, f: f, dn: dn, er: 1'b0, c: exp_code, dly: 0});
  endtask

  task automatic exp_done();
    sb.push_back('{v: 4'b0, d: 8'h00, f: 1'b0, dn: 1'b1, er: 1'b0, c: exp_code, dly: 0});
  endtask

  task automatic exp_err(input logic [2:0] c, input int dly);
    exp_code = c;
    sb.push_back('{v: 4'b0, d: 8'h00, f: 1'b0, dn: 1'b0, er: 1'b1, c: c, dly: dly});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Sends id, len and the bytes in 'pay' to target 'sel' and queues the strobes.
  task automatic send_frame(input logic [7:0] id, input int sel);
    logic [7:0] x;
    logic [3:0] oh;
    oh = 4'b0001 << sel;
    x  = id ^ 8'(pay.size());
    send_byte(id);
    send_byte(8'(pay.size()));
    for (int k = 0; k < pay.size(); k++) begin
      x = x ^ pay[k];
`ifdef UART_DISPATCH_CSUM_EN
      exp_tgt(oh, pay[k], k == 0, 1'b0);
`else
      exp_tgt(oh, pay[k], k == 0, k == pay.size() - 1);
`endif
      send_byte(pay[k]);
    end
`ifdef UART_DISPATCH_CSUM_EN
    exp_done();
    send_byte(x);
`endif
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, {28'd0, tgt_valid}, 32'd0);
    chk({nm, "_flags"}, {28'd0, tgt_first, frame_done, frame_error, busy}, 32'd0);
    chk({nm, "_data"}, {24'd0, tgt_data}, 32'd0);
    chk({nm, "_code"}, {29'd0, err_code}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    reset = 1'b0;

    // 1. two-byte frame to target 1
    pay = '{8'hB6, 8'hA7};
    send_frame(8'h15, 1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_code", {29'd0, err_code}, 32'd0);

    // 2. bad id, then good frame
    exp_err(3'd1, 0);
    send_byte(8'h30);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    pay = '{8'h7A};
    send_frame(8'h14, 0);

    // 3. length boundaries
    send_byte(8'h14);
    exp_err(3'd2, 0);
    send_byte(8'h00);
    send_byte(8'h14);
    exp_err(3'd2, 0);
    send_byte(8'h11);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    pay = {};
    for (int i = 0; i < 16; i++) pay.push_back(8'(i * 17 + 3));
    send_frame(8'h14, 0);

    // 4. timeout after the first payload byte
    send_byte(8'h16);
    send_byte(8'h03);
    exp_tgt(4'b0100, 8'h7A, 1'b1, 1'b0);
    exp_err(3'd3, T);
    send_byte(8'h7A);
    repeat (T + 10) @(posedge clk);
    #1 chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_code", {29'd0, err_code}, 32'd3);

    // 5. reset mid-frame
    send_byte(8'h17);
    send_byte(8'h02);
    exp_tgt(4'b1000, 8'h01, 1'b1, 1'b0);
    send_byte(8'h01);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 chk_zero("t5_rst");
    reset = 1'b0;
    exp_code = 3'd0;
    exp_err(3'd1, 0);
    send_byte(8'h02);
    // byte held high across reset must not be accepted
    @(posedge clk); #1;
    rx_data  = 8'h14;
    rx_ready = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_code = 3'd0;
    repeat (4) @(posedge clk);
    #1 chk("t5_hold_busy", {31'd0, busy}, 32'd0);
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk("t5_hold_code", {29'd0, err_code}, 32'd0);
    pay = '{8'h55};
    send_frame(8'h17, 3);

`ifdef UART_DISPATCH_CSUM_EN
    // 6. checksum good and bad
    send_byte(8'h15);
    send_byte(8'h01);
    exp_tgt(4'b0010, 8'h7A, 1'b1, 1'b0);
    send_byte(8'h7A);
    exp_done();
    send_byte(8'h6E);
    send_byte(8'h15);
    send_byte(8'h01);
    exp_tgt(4'b0010, 8'h7A, 1'b1, 1'b0);
    send_byte(8'h7A);
    exp_err(3'd4, 0);
    send_byte(8'h00);
    chk("t6_code", {29'd0, err_code}, 32'd4);
`endif

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
